// File: rtl/ret_marker_pkg.sv
// rtl/ret_marker_pkg.sv - shared types and RET/MARKER classification helpers
package ret_marker_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] BREAKPOINT = 64'd3;

    typedef enum logic [3:0] {
        ADD,
        SUB,
        JAL,
        JALR,
        LOAD,
        STORE
    } fu_op_t;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        fu_op_t          op;
        logic [5:0]      rs1;
        logic [5:0]      rd;
        logic [XLEN-1:0] result;
        exception_t      ex;
    } scoreboard_entry_t;

    typedef enum logic {
        IDLE,
        CHECK
    } chk_state_t;

    // RET is "jalr x0, 0(x1)" that committed without an exception
    function automatic logic is_ret_slot(input logic ack, input scoreboard_entry_t e);
        return ack && !e.ex.valid && (e.op == JALR) && (e.rd == 6'd0) && (e.rs1 == 6'd1);
    endfunction

    // Marker NOP: immediate lands in result for ALU ops
    function automatic logic is_marker_slot(input logic ack, input scoreboard_entry_t e,
                                            input fu_op_t nop_op, input logic [4:0] nop_rd,
                                            input logic [4:0] nop_rs1, input logic [4:0] nop_imm);
        return ack && (e.op == nop_op) && (e.rd[4:0] == nop_rd) &&
               (e.rs1[4:0] == nop_rs1) && (e.result[4:0] == nop_imm);
    endfunction

endpackage

// File: rtl/commit_slot_classify.sv
// rtl/commit_slot_classify.sv - combinational RET/MARKER classifier for one commit port
module commit_slot_classify
    import ret_marker_pkg::*;
#(
    parameter fu_op_t     NOP_OP  = ADD,
    parameter logic [4:0] NOP_RD  = 5'd0,
    parameter logic [4:0] NOP_RS1 = 5'd0,
    parameter logic [4:0] NOP_IMM = 5'd1
) (
    input  logic              ack,
    input  scoreboard_entry_t instr,
    output logic              is_ret,
    output logic              is_marker
);

    logic unused_bits;
    assign unused_bits = ^{instr.pc, instr.result[XLEN-1:5], instr.ex.cause, instr.ex.tval};

    assign is_ret    = is_ret_slot(ack, instr);
    assign is_marker = is_marker_slot(ack, instr, NOP_OP, NOP_RD, NOP_RS1, NOP_IMM);

endmodule

// File: rtl/ret_marker_checker_commit.sv
// rtl/ret_marker_checker_commit.sv - checks that every committed RET is followed by marker NOPs
module ret_marker_checker_commit
    import ret_marker_pkg::*;
#(
    parameter int         NR_COMMIT_PORTS = 2,
    parameter int         MARKER_LEN      = 1,
    parameter fu_op_t     NOP_OP          = ADD,
    parameter logic [4:0] NOP_RD          = 5'd0,
    parameter logic [4:0] NOP_RS1         = 5'd0,
    parameter logic [4:0] NOP_IMM         = 5'd1,
    parameter int         CNT_W           = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   enable_i,
    input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
    input  scoreboard_entry_t      commit_instr_i [NR_COMMIT_PORTS],
    output exception_t             exception_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       violation_cnt_o
);

    localparam logic [3:0] MLEN = 4'(MARKER_LEN);

    chk_state_t           state_q, state_d;
    logic [3:0]           rem_q, rem_d;
    exception_t           exc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 viol;
    logic [XLEN-1:0]      viol_pc;
    logic [NR_COMMIT_PORTS-1:0] is_ret, is_marker;

    genvar g;
    generate
        for (g = 0; g < NR_COMMIT_PORTS; g++) begin : g_cls
            commit_slot_classify #(
                .NOP_OP (NOP_OP),
                .NOP_RD (NOP_RD),
                .NOP_RS1(NOP_RS1),
                .NOP_IMM(NOP_IMM)
            ) u_cls (
                .ack      (commit_ack_i[g]),
                .instr    (commit_instr_i[g]),
                .is_ret   (is_ret[g]),
                .is_marker(is_marker[g])
            );
        end
    endgenerate

    // Walk acked slots in port order; a violation stops evaluation for the cycle
    always_comb begin
        logic stop;
        state_d = state_q;
        rem_d   = rem_q;
        viol    = 1'b0;
        viol_pc = '0;
        stop    = 1'b0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (!stop && commit_ack_i[i]) begin
                if (state_d == IDLE) begin
                    if (is_ret[i]) begin
                        state_d = CHECK;
                        rem_d   = MLEN;
                    end
                end else if (is_marker[i]) begin
                    rem_d = rem_d - 4'd1;
                    if (rem_d == 4'd0) begin
                        state_d = IDLE;
                    end
                end else begin
                    viol    = 1'b1;
                    viol_pc = commit_instr_i[i].pc;
                    state_d = IDLE;
                    rem_d   = 4'd0;
                    stop    = 1'b1;
                end
            end
        end
        if (flush_i) begin
            state_d = IDLE;
            rem_d   = 4'd0;
            viol    = 1'b0;
            viol_pc = '0;
        end
    end

    // State, exception and saturating violation counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rem_q   <= 4'd0;
            exc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (viol && enable_i) begin
                exc_q.valid <= 1'b1;
                exc_q.cause <= BREAKPOINT;
                exc_q.tval  <= viol_pc;
            end else begin
                exc_q <= '0;
            end
            if (viol && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign exception_o     = exc_q;
    assign busy_o          = (state_q == CHECK);
    assign violation_cnt_o = cnt_q;

endmodule

// File: tb/tb_ret_marker_checker_commit.sv
// tb/tb_ret_marker_checker_commit.sv - scoreboard bench for ret_marker_checker_commit
module tb_ret_marker_checker_commit;
    import ret_marker_pkg::*;

    typedef struct {
        bit          sel;
        logic        ev;
        logic [63:0] tval;
        logic        busy;
        int          cnt;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        ack_a = '0, ack_b = '0;
    scoreboard_entry_t ins_a [2];
    scoreboard_entry_t ins_b [2];
    logic              flush_a = 1'b0, flush_b = 1'b0, en_a = 1'b1, en_b = 1'b1;
    exception_t        ex_a, ex_b;
    logic              busy_a, busy_b;
    logic [2:0]        cnt_a;
    logic [15:0]       cnt_b;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    ret_marker_checker_commit #(.NR_COMMIT_PORTS(2), .MARKER_LEN(1), .CNT_W(3)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a), .enable_i(en_a),
        .commit_ack_i(ack_a), .commit_instr_i(ins_a),
        .exception_o(ex_a), .busy_o(busy_a), .violation_cnt_o(cnt_a)
    );

    ret_marker_checker_commit #(.NR_COMMIT_PORTS(2), .MARKER_LEN(2), .CNT_W(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_b), .enable_i(en_b),
        .commit_ack_i(ack_b), .commit_instr_i(ins_b),
        .exception_o(ex_b), .busy_o(busy_b), .violation_cnt_o(cnt_b)
    );

    function automatic scoreboard_entry_t mk(input logic [63:0] pc, input fu_op_t op,
                                             input logic [5:0] rd, input logic [5:0] rs1,
                                             input logic [63:0] res, input logic exv);
        scoreboard_entry_t e;
        e        = '0;
        e.pc     = pc;
        e.op     = op;
        e.rd     = rd;
        e.rs1    = rs1;
        e.result = res;
        e.ex.valid = exv;
        return e;
    endfunction

    function automatic scoreboard_entry_t ret_i(input logic [63:0] pc);
        return mk(pc, JALR, 6'd0, 6'd1, 64'd0, 1'b0);
    endfunction
    function automatic scoreboard_entry_t nop_i(input logic [63:0] pc);
        return mk(pc, ADD, 6'd0, 6'd0, 64'd1, 1'b0);
    endfunction
    function automatic scoreboard_entry_t addi2(input logic [63:0] pc);
        return mk(pc, ADD, 6'd0, 6'd0, 64'd2, 1'b0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input bit sel, input logic [1:0] ack, input scoreboard_entry_t s0,
                        input scoreboard_entry_t s1, input logic fl, input logic en,
                        input logic ev, input logic [63:0] tval, input logic busy,
                        input int cnt, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        if (!sel) begin
            ack_a = ack; ins_a[0] = s0; ins_a[1] = s1; flush_a = fl; en_a = en;
            ack_b = '0; flush_b = 1'b0;
        end else begin
            ack_b = ack; ins_b[0] = s0; ins_b[1] = s1; flush_b = fl; en_b = en;
            ack_a = '0; flush_a = 1'b0;
        end
        e = '{sel, ev, tval, busy, cnt, nm};
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input bit sel, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        ack_a = '0; ack_b = '0; flush_a = 1'b0; flush_b = 1'b0;
        e = '{sel, 1'b0, 64'd0, 1'b0, 0, nm};
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per cycle, checked just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!e.sel) begin
                    chk({e.nm, ".valid"}, 64'(ex_a.valid), 64'(e.ev));
                    chk({e.nm, ".cause"}, ex_a.cause, e.ev ? 64'd3 : 64'd0);
                    chk({e.nm, ".tval"},  ex_a.tval, e.ev ? e.tval : 64'd0);
                    chk({e.nm, ".busy"},  64'(busy_a), 64'(e.busy));
                    chk({e.nm, ".cnt"},   64'(cnt_a), 64'(e.cnt));
                end else begin
                    chk({e.nm, ".valid"}, 64'(ex_b.valid), 64'(e.ev));
                    chk({e.nm, ".cause"}, ex_b.cause, e.ev ? 64'd3 : 64'd0);
                    chk({e.nm, ".tval"},  ex_b.tval, e.ev ? e.tval : 64'd0);
                    chk({e.nm, ".busy"},  64'(busy_b), 64'(e.busy));
                    chk({e.nm, ".cnt"},   64'(cnt_b), 64'(e.cnt));
                end
            end
        end
    end

    initial begin
        scoreboard_entry_t z;
        z = mk(64'd0, SUB, 6'd5, 6'd6, 64'd0, 1'b0);
        ins_a[0] = z; ins_a[1] = z; ins_b[0] = z; ins_b[1] = z;

        do_reset(1'b0, "reset_a");
        do_reset(1'b1, "reset_b");

        // MARKER_LEN=1 instance
        step(0, 2'b01, ret_i(64'h80000100), z, 0, 1, 0, 0, 1, 0, "ret_enter");
        step(0, 2'b01, nop_i(64'h80000104), z, 0, 1, 0, 0, 0, 0, "marker_ok");
        step(0, 2'b00, z, z, 0, 1, 0, 0, 0, 0, "idle");
        step(0, 2'b11, ret_i(64'h80000100), addi2(64'h80000104), 0, 1, 1, 64'h80000104, 0, 1, "bad_marker");
        step(0, 2'b00, z, z, 0, 1, 0, 0, 0, 1, "exc_one_cycle");
        step(0, 2'b11, ret_i(64'h100), nop_i(64'h104), 0, 1, 0, 0, 0, 1, "ret_mark_same");
        step(0, 2'b01, ret_i(64'h108), z, 0, 1, 0, 0, 1, 1, "reenter");
        step(0, 2'b01, ret_i(64'h200), z, 0, 1, 1, 64'h200, 0, 2, "ret_in_check");
        step(0, 2'b01, ret_i(64'h210), addi2(64'h214), 0, 1, 0, 0, 1, 2, "unacked_slot");
        step(0, 2'b00, z, z, 0, 1, 0, 0, 1, 2, "check_holds");
        step(0, 2'b01, addi2(64'h300), z, 0, 0, 0, 0, 0, 3, "disabled_viol");
        step(0, 2'b01, ret_i(64'h310), z, 0, 1, 0, 0, 1, 3, "ret_pre_flush");
        step(0, 2'b01, addi2(64'h314), z, 1, 1, 0, 0, 0, 3, "flush");
        step(0, 2'b11, addi2(64'h320), ret_i(64'h324), 0, 1, 0, 0, 1, 3, "idle_then_ret");
        step(0, 2'b11, addi2(64'h400), addi2(64'h404), 0, 1, 1, 64'h400, 0, 4, "first_viol_wins");
        step(0, 2'b01, mk(64'h410, JALR, 6'd0, 6'd1, 64'd0, 1'b1), z, 0, 1, 0, 0, 0, 4, "exc_ret_ignored");
        for (int k = 1; k <= 4; k++) begin
            step(0, 2'b11, ret_i(64'h600), addi2(64'h600 + 64'(k) * 8), 0, 1, 1,
                 64'h600 + 64'(k) * 8, 0, (4 + k > 7) ? 7 : 4 + k, "saturate");
        end
        step(0, 2'b00, z, z, 0, 1, 0, 0, 0, 7, "sat_hold");
        step(0, 2'b01, ret_i(64'h700), z, 0, 1, 0, 0, 1, 7, "ret_pre_reset");
        do_reset(1'b0, "reset_mid_check");
        step(0, 2'b01, addi2(64'h704), z, 0, 1, 0, 0, 0, 0, "after_reset");

        // MARKER_LEN=2 instance
        step(1, 2'b01, ret_i(64'h800), z, 0, 1, 0, 0, 1, 0, "b_ret");
        step(1, 2'b01, nop_i(64'h804), z, 0, 1, 0, 0, 1, 0, "b_mark1");
        for (int k = 0; k < 3; k++) step(1, 2'b00, z, z, 0, 1, 0, 0, 1, 0, "b_gap");
        step(1, 2'b01, nop_i(64'h808), z, 0, 1, 0, 0, 0, 0, "b_mark2");
        step(1, 2'b01, ret_i(64'h900), z, 0, 1, 0, 0, 1, 0, "b_ret2");
        step(1, 2'b01, nop_i(64'h904), z, 0, 1, 0, 0, 1, 0, "b_mark_a");
        step(1, 2'b01, addi2(64'h500), z, 0, 1, 1, 64'h500, 0, 1, "b_viol");
        step(1, 2'b11, ret_i(64'ha00), nop_i(64'ha04), 0, 1, 0, 0, 1, 1, "b_ret_mark");
        step(1, 2'b11, nop_i(64'ha08), ret_i(64'ha0c), 0, 1, 0, 0, 1, 1, "b_done_reret");
        step(1, 2'b11, nop_i(64'ha10), nop_i(64'ha14), 0, 1, 0, 0, 0, 1, "b_two_marks");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
